fft_out_serializer: RTL and testbench

Drains one completed 64-point FFT/IFFT result frame from the `FFT` block's parallel `output_Re`/`output_Im` arrays and streams it out one complex sample per handshake. It sits on the result side of `FFT`, mirroring the input-side loader that fills `input_Re`/`input_Im` and pulses `start`. The frame is snapshotted on a single `capture` pulse, so `FFT` may begin its next transform while the serializer is still streaming.

---
 rtl/fft_pkg.sv | 21 ++
 rtl/fft_frame_buffer.sv | 31 +++
 rtl/fft_out_serializer.sv | 145 ++++++++++++++
 tb/tb_fft_out_serializer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: frame geometry, sample type and bin-index reversal.
package fft_pkg;

  localparam int unsigned N_POINTS = 64;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned IDX_W    = $clog2(N_POINTS);

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [IDX_W-1:0]    idx_t;

  // Reverse the bit order of a frequency-bin index.
  function automatic idx_t bitrev(input idx_t idx);
    idx_t r;
    r = '0;
    for (int unsigned b = 0; b < IDX_W; b++) begin
      r[b] = idx[IDX_W-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_buffer.sv
// Frame store: parallel load of a whole complex frame, one combinational indexed read port.
module fft_frame_buffer #(
  parameter int unsigned N_POINTS = 64,
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic                        clk,
  input  logic                        load,
  input  logic [SAMPLE_W-1:0]         load_re [N_POINTS],
  input  logic [SAMPLE_W-1:0]         load_im [N_POINTS],
  input  logic [$clog2(N_POINTS)-1:0] rd_idx,
  output logic [SAMPLE_W-1:0]         rd_re_c,
  output logic [SAMPLE_W-1:0]         rd_im_c
);

  logic [SAMPLE_W-1:0] mem_re [N_POINTS];
  logic [SAMPLE_W-1:0] mem_im [N_POINTS];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int unsigned i = 0; i < N_POINTS; i++) begin
        mem_re[i] <= load_re[i];
        mem_im[i] <= load_im[i];
      end
    end
  end

  assign rd_re_c = mem_re[rd_idx];
  assign rd_im_c = mem_im[rd_idx];

endmodule

// File: rtl/fft_out_serializer.sv
// Snapshots a completed FFT result frame on capture and streams it out one complex
// sample per valid/ready handshake, in natural or bit-reversed bin order.
module fft_out_serializer #(
  parameter int unsigned N_POINTS = fft_pkg::N_POINTS,
  parameter int unsigned SAMPLE_W = fft_pkg::SAMPLE_W,
  parameter int unsigned BITREV   = 0,
  localparam int unsigned IDX_W   = $clog2(N_POINTS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] in_Re [N_POINTS],
  input  logic [SAMPLE_W-1:0] in_Im [N_POINTS],
  input  logic                capture,
  output logic                busy,
  output logic                overrun,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] out_Re,
  output logic [SAMPLE_W-1:0] out_Im,
  output logic [IDX_W-1:0]    out_idx,
  output logic                out_last
);

  import fft_pkg::*;

  localparam logic [0:0]       IDLE     = 1'b0;
  localparam logic [0:0]       STREAM   = 1'b1;
  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(N_POINTS - 1);

  logic [0:0]          state;
  logic [0:0]          state_nxt;
  logic [IDX_W-1:0]    cnt;
  logic [IDX_W-1:0]    cnt_nxt;
  logic [IDX_W-1:0]    cnt_inc;
  logic [IDX_W-1:0]    rd_idx;
  logic [SAMPLE_W-1:0] buf_re_c;
  logic [SAMPLE_W-1:0] buf_im_c;
  logic                load;
  logic                fire_c;
  logic                take_frame_c;
  logic [SAMPLE_W-1:0] re_nxt;
  logic [SAMPLE_W-1:0] im_nxt;
  logic [IDX_W-1:0]    idx_nxt;
  logic                last_nxt;
  logic                overrun_nxt;

  // Counter-to-bin mapping: identity, or bit reversal of the bin index.
  function automatic logic [IDX_W-1:0] map_idx(input logic [IDX_W-1:0] c);
    if (BITREV != 0) begin
      return IDX_W'(bitrev(idx_t'(c)));
    end
    return c;
  endfunction

  assign busy      = (state == STREAM);
  assign out_valid = (state == STREAM);
  assign fire_c    = out_valid && out_ready;
  assign cnt_inc   = cnt + IDX_W'(1);
  // The read port looks one sample ahead so the output register loads on transfer.
  assign rd_idx    = map_idx(cnt_inc);

  // A new frame is taken from idle, or on the final transfer for back-to-back frames.
  assign take_frame_c = capture && ((state == IDLE) || (fire_c && out_last));

  fft_frame_buffer #(
    .N_POINTS (N_POINTS),
    .SAMPLE_W (SAMPLE_W)
  ) u_frame_buffer (
    .clk     (clk),
    .load    (load),
    .load_re (in_Re),
    .load_im (in_Im),
    .rd_idx  (rd_idx),
    .rd_re_c (buf_re_c),
    .rd_im_c (buf_im_c)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      out_Re   <= '0;
      out_Im   <= '0;
      out_idx  <= '0;
      out_last <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      out_Re   <= re_nxt;
      out_Im   <= im_nxt;
      out_idx  <= idx_nxt;
      out_last <= last_nxt;
      overrun  <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    re_nxt      = out_Re;
    im_nxt      = out_Im;
    idx_nxt     = out_idx;
    last_nxt    = out_last;
    overrun_nxt = 1'b0;
    load        = 1'b0;

    if (take_frame_c) begin
      // Bin 0 maps to itself in both orders, so the first sample bypasses the buffer.
      load      = 1'b1;
      state_nxt = STREAM;
      cnt_nxt   = '0;
      re_nxt    = in_Re[0];
      im_nxt    = in_Im[0];
      idx_nxt   = '0;
      last_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = IDLE;
        end
        STREAM: begin
          overrun_nxt = capture;
          if (fire_c) begin
            if (out_last) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
              last_nxt  = 1'b0;
            end else begin
              cnt_nxt  = cnt_inc;
              re_nxt   = buf_re_c;
              im_nxt   = buf_im_c;
              idx_nxt  = rd_idx;
              last_nxt = (cnt_inc == LAST_CNT);
            end
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Scoreboard bench: natural-order and bit-reversed serializers driven side by side.
module tb_fft_out_serializer;

  localparam int NP = 64;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
    logic [5:0]  idx;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        capture;
  logic        out_ready;
  logic [15:0] in_re [NP];
  logic [15:0] in_im [NP];

  logic        o_busy  [2];
  logic        o_ovr   [2];
  logic        o_valid [2];
  logic        o_last  [2];
  logic [15:0] o_re    [2];
  logic [15:0] o_im    [2];
  logic [5:0]  o_idx   [2];

  exp_t q [2][$];
  exp_t prev [2];
  exp_t e_m;
  bit   stall [2];
  bit   exp_ovr = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fft_out_serializer #(.N_POINTS(NP), .SAMPLE_W(16), .BITREV(0)) u_nat (
    .clk(clk), .rst(rst), .in_Re(in_re), .in_Im(in_im), .capture(capture),
    .busy(o_busy[0]), .overrun(o_ovr[0]), .out_valid(o_valid[0]), .out_ready(out_ready),
    .out_Re(o_re[0]), .out_Im(o_im[0]), .out_idx(o_idx[0]), .out_last(o_last[0])
  );

  fft_out_serializer #(.N_POINTS(NP), .SAMPLE_W(16), .BITREV(1)) u_rev (
    .clk(clk), .rst(rst), .in_Re(in_re), .in_Im(in_im), .capture(capture),
    .busy(o_busy[1]), .overrun(o_ovr[1]), .out_valid(o_valid[1]), .out_ready(out_ready),
    .out_Re(o_re[1]), .out_Im(o_im[1]), .out_idx(o_idx[1]), .out_last(o_last[1])
  );

  task automatic check(input string name, input int n, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, n, act, expv, $time);
    end
  endtask

  // Bin index with its six bits read back to front, by repeated halving.
  function automatic int rev6(input int x);
    int r;
    int v;
    r = 0;
    v = x;
    for (int b = 0; b < 6; b++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  task automatic set_ramp();
    for (int i = 0; i < NP; i++) begin
      in_re[i] = 16'(i);
      in_im[i] = 16'(16'hFFFF - i);
    end
  endtask

  task automatic set_random();
    for (int i = 0; i < NP; i++) begin
      in_re[i] = 16'($urandom);
      in_im[i] = 16'($urandom);
    end
  endtask

  // Expected emission order for an accepted frame, per instance.
  task automatic push_frame();
    exp_t e;
    int   b;
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < NP; k++) begin
        b      = (n == 0) ? k : rev6(k);
        e.re   = in_re[b];
        e.im   = in_im[b];
        e.idx  = 6'(b);
        e.last = (k == NP - 1);
        q[n].push_back(e);
      end
    end
  endtask

  // One clock: drive inputs, decide acceptance from the frame model, advance past the edge.
  task automatic step(input bit cap, input bit rdy);
    bit acc;
    bit rst_now;
    capture   = cap;
    out_ready = rdy;
    rst_now   = rst;
    acc = cap && rst_now && ((q[0].size() == 0) || ((q[0].size() == 1) && rdy));
    @(posedge clk);
    if (!rst_now) begin
      q[0].delete();
      q[1].delete();
      exp_ovr = 1'b0;
    end else begin
      exp_ovr = cap && !acc;
    end
    if (acc) push_frame();
    #1;
    if (!rst_now) begin
      for (int n = 0; n < 2; n++) begin
        check("rst_ctl", n, 32'({o_valid[n], o_busy[n], o_last[n], o_ovr[n]}), 32'(0));
        check("rst_data", n, {o_re[n], o_im[n]}, 32'(0));
        check("rst_idx", n, 32'(o_idx[n]), 32'(0));
      end
    end
    capture = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (q[0].size() == 0 && q[1].size() == 0) break;
      step(1'b0, 1'b1);
    end
    for (int n = 0; n < 2; n++) check("drain", n, 32'(q[n].size()), 32'(0));
  endtask

  // Monitor: protocol and scoreboard checks at the falling edge.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      for (int n = 0; n < 2; n++) begin
        if (stall[n]) begin
          check("stall_data", n, {o_re[n], o_im[n]}, {prev[n].re, prev[n].im});
          check("stall_ctl", n, 32'({o_valid[n], o_last[n], o_idx[n]}),
                32'({1'b1, prev[n].last, prev[n].idx}));
        end
        check("valid", n, 32'(o_valid[n]), 32'(q[n].size() != 0));
        check("busy", n, 32'(o_busy[n]), 32'(q[n].size() != 0));
        check("overrun", n, 32'(o_ovr[n]), 32'(exp_ovr));
        if (o_valid[n] && out_ready) begin
          if (q[n].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra_xfer inst%0d: got idx %0d expected no transfer at %0t", n, o_idx[n], $time);
          end else begin
            e_m = q[n].pop_front();
            check("re", n, 32'(o_re[n]), 32'(e_m.re));
            check("im", n, 32'(o_im[n]), 32'(e_m.im));
            check("idx", n, 32'(o_idx[n]), 32'(e_m.idx));
            check("last", n, 32'(o_last[n]), 32'(e_m.last));
          end
        end
        stall[n]     = o_valid[n] && !out_ready;
        prev[n].re   = o_re[n];
        prev[n].im   = o_im[n];
        prev[n].idx  = o_idx[n];
        prev[n].last = o_last[n];
      end
    end else begin
      stall[0] = 1'b0;
      stall[1] = 1'b0;
    end
  end

  initial begin
    rst       = 1'b0;
    capture   = 1'b0;
    out_ready = 1'b0;
    set_ramp();
    @(posedge clk);
    #1;

    // Reset held three cycles, with a capture pulse that must be ignored.
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    rst = 1'b1;
    step(1'b0, 1'b1);

    // Natural/bit-reversed order on ramp data, ready held high.
    set_ramp();
    step(1'b1, 1'b1);
    for (int i = 0; i < 70; i++) step(1'b0, 1'b1);
    for (int n = 0; n < 2; n++) check("ramp_done", n, 32'(q[n].size()), 32'(0));

    // Random backpressure while the source data keeps changing.
    set_random();
    step(1'b1, 1'($urandom % 2));
    for (int i = 0; i < 600; i++) begin
      if (q[0].size() == 0) break;
      for (int j = 0; j < NP; j++) in_re[j] = 16'($urandom);
      step(1'b0, 1'($urandom % 2));
    end
    drain(10);

    // Capture at transfer 10 is rejected and flagged.
    set_random();
    step(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    set_random();
    step(1'b1, 1'b1);
    drain(100);

    // Back-to-back frame on the final transfer, then reset at transfer 20.
    set_random();
    step(1'b1, 1'b1);
    for (int i = 0; i < 200 && q[0].size() != 1; i++) step(1'b0, 1'b1);
    check("b2b_sync", 0, 32'(q[0].size()), 32'(1));
    set_random();
    step(1'b1, 1'b1);
    for (int i = 0; i < 200 && q[0].size() > NP - 20; i++) step(1'b0, 1'b1);
    check("rst_sync", 0, 32'(q[0].size()), 32'(NP - 20));
    rst = 1'b0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    rst = 1'b1;
    step(1'b0, 1'b1);
    set_random();
    step(1'b1, 1'b1);
    drain(100);

    // Random mix of captures, stalls and data churn.
    for (int i = 0; i < 600; i++) begin
      if ($urandom % 16 == 0) set_random();
      step(1'($urandom % 16 == 0), 1'($urandom % 4 != 0));
    end
    drain(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
